comparator_sequencer: RTL
=========================

Name: comparator_sequencer

Overview:
- Digital controller that shares the on-chip analog comparator between NREQ digital requesters.
- Round-robin arbitrates requests and drives the analog input-mux select.
- Enables comparator bias, waits a settle time, then samples the comparator output through a synchroniser.
- Returns a one-bit decision with a one-cycle ack.
- Sits in the user project area between the Wishbone-side logic and the comparator macro.

Parameters:
- NREQ, 4, number of requesters / mux channels (2..8)
- SEL_W, 2, mux select width; must equal clog2(NREQ)
- SETTLE_CYC, 8, cycles bias and mux are held before sampling (>=3, covers 2-flop sync latency)
- NSAMP, 5, samples taken for majority vote (odd, 1..15; used only with COMP_MAJORITY_EN)

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  asynchronous, active-high reset
- req_i  input  NREQ  level request per requester; held until ack
- ack_o  output  NREQ  one-cycle pulse to the served requester
- result_o  output  1  decision: 1 = VINP > VINM; valid in ack cycle, held until next ack
- sel_o  output  SEL_W  analog mux channel select
- bias_en_o  output  1  enables VBN/VBP bias generation
- comp_i  input  1  raw comparator VOUT (asynchronous to wb_clk_i)
- busy_o  output  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset is asynchronous and active-high on wb_rst_i.
- Reset values: ack_o=0, result_o=0, sel_o=0, bias_en_o=0, busy_o=0, state=IDLE, rr_ptr=0, sync flops=0.
- Reset asserted mid-conversion aborts immediately: no ack is issued and bias drops asynchronously.
- FSM states:
  - IDLE: if any req_i is set, grant the first set bit at or after rr_ptr, wrapping modulo NREQ. Register sel_o=grant and go to SETTLE.
  - SETTLE: bias_en_o=1, sel_o held. Counter runs SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE: 1 cycle, or NSAMP cycles with the majority feature. Samples the synchronised comparator output. Then go to DONE.
  - DONE: ack_o[sel_o]=1 for exactly one cycle, result_o updated, rr_ptr=sel_o+1 mod NREQ, then go to IDLE.
- Bias: bias_en_o is high in SETTLE, SAMPLE and DONE; low in IDLE.
- Latency: a request first seen in IDLE at edge k gives ack high in cycle k+1+SETTLE_CYC+S+... exactly k+SETTLE_CYC+S+1, where S = sample cycles (1 or NSAMP).
- Back-to-back: DONE always returns to IDLE, giving one idle cycle. The requester drops req the cycle after ack, so it is not re-granted.
- Request withdrawn mid-conversion: the conversion completes and the ack is still pulsed. Requesters ignore unexpected acks.
- Simultaneous requests: strict round-robin. Each requester is served at most once per NREQ grants while others are pending.
- Requests arriving outside IDLE wait; arbitration happens only in IDLE.
- Counters: the settle counter is clog2(SETTLE_CYC+1) bits and the vote counter is clog2(NSAMP+1) bits. Both saturate-free and are cleared on entry to each state.

Optional Feature:
- Macro: COMP_MAJORITY_EN.
- Defined: SAMPLE lasts NSAMP cycles and counts synchronised ones; result = count > NSAMP/2. This filters comparator chatter near the threshold.
- Undefined: SAMPLE lasts 1 cycle; result = the synchronised value in that cycle. NSAMP is ignored and the vote counter is not built.

Decomposition:
- Package comparator_seq_pkg holds:
  - state enum: IDLE, SETTLE, SAMPLE, DONE
  - default constants for SETTLE_CYC and NSAMP
  - clog2-based width helpers
- Sub-module comparator_sync: 2-flop synchroniser for comp_i, with async reset to 0.

Test Plan:
- Single request: NREQ=4, SETTLE_CYC=8, no majority, comp_i=1, req_i=4'b0100 at edge 0 -> sel_o=2 from cycle 1; bias_en_o high cycles 1..10; ack_o=4'b0100 in cycle 10 only; result_o=1.
- Round-robin: req_i=4'b1111 held continuously -> grant order 0,1,2,3,0; each ack one cycle; one IDLE cycle between conversions.
- Majority (COMP_MAJORITY_EN, NSAMP=5): comp_i pattern 1,0,1,1,0 over the sample window -> result_o=1. Pattern 0,0,1,0,1 -> result_o=0.
- Reset mid-op: assert wb_rst_i during SETTLE -> bias_en_o, busy_o and sel_o go to 0 without waiting for a clock edge; no ack; the first grant after release goes to requester 0.
- Withdrawal: req_i[1] drops during SETTLE -> ack_o[1] still pulses at the nominal cycle; next grant starts from rr_ptr=2.
- Glitchy comp_i: toggle comp_i asynchronously during SETTLE only, stable 0 in SAMPLE -> result_o=0; no X on outputs.

Source files
------------

// File: rtl/comparator_sequencer_pkg.sv
// Shared types and width helpers for the comparator sequencer.
package comparator_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int unsigned SETTLE_CYC_DEF = 8;
    localparam int unsigned NSAMP_DEF      = 5;

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/comparator_sequencer_sync.sv
// Two-flop synchroniser bringing the raw comparator output into wb_clk_i.
module comparator_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/comparator_sequencer.sv
// Round-robin sequencer sharing one analog comparator between NREQ requesters.
// Define COMP_MAJORITY_EN to take NSAMP samples and majority-vote the decision.
module comparator_sequencer
    import comparator_seq_pkg::*;
#(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int unsigned NSAMP      = NSAMP_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  ack_o,
    output logic             result_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             bias_en_o,
    input  logic             comp_i,
    output logic             busy_o
);

    if (SEL_W != $clog2(NREQ)) begin : g_bad_sel_w
        $error("SEL_W must equal clog2(NREQ)");
    end
    if (SETTLE_CYC < 3) begin : g_bad_settle
        $error("SETTLE_CYC must cover the synchroniser latency");
    end
    if ((NSAMP % 2) == 0 || NSAMP > 15) begin : g_bad_nsamp
        $error("NSAMP must be odd and at most 15");
    end

`ifdef COMP_MAJORITY_EN
    localparam int unsigned SAMP_CYC = NSAMP;
    localparam int unsigned VCNT_W   = cnt_w(NSAMP);
`else
    localparam int unsigned SAMP_CYC = 1;
`endif
    localparam int unsigned CNT_W = cnt_w(max_u(SETTLE_CYC, SAMP_CYC));

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  rr_q;
    logic [NREQ-1:0]   ack_q;
    logic              result_q;
    logic              bias_q;
    logic              busy_q;
    logic              comp_sync;
    logic [SEL_W-1:0]  grant_d;
    logic [SEL_W-1:0]  rr_d;
    logic [SEL_W:0]    cand;
    logic [SEL_W:0]    rr_inc;
    logic              found;

    comparator_sync u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (comp_i),
        .q_o   (comp_sync)
    );

`ifdef COMP_MAJORITY_EN
    logic [VCNT_W-1:0] vote_q;
    logic [VCNT_W-1:0] vote_d;
    assign vote_d = vote_q + VCNT_W'(comp_sync);
`endif

    // Scan from rr_q upward, wrapping at NREQ, and take the first pending request.
    always_comb begin
        grant_d = rr_q;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_q} + (SEL_W+1)'(i);
            if (cand >= (SEL_W+1)'(NREQ)) cand = cand - (SEL_W+1)'(NREQ);
            if (!found && req_i[cand[SEL_W-1:0]]) begin
                grant_d = cand[SEL_W-1:0];
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        rr_inc = {1'b0, sel_q} + (SEL_W+1)'(1);
        if (rr_inc == (SEL_W+1)'(NREQ)) rr_inc = '0;
        rr_d = rr_inc[SEL_W-1:0];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            rr_q     <= '0;
            ack_q    <= '0;
            result_q <= 1'b0;
            bias_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef COMP_MAJORITY_EN
            vote_q   <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req_i) begin
                        sel_q   <= grant_d;
                        cnt_q   <= '0;
                        bias_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt_q   <= '0;
`ifdef COMP_MAJORITY_EN
                        vote_q  <= '0;
`endif
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
`ifdef COMP_MAJORITY_EN
                    vote_q <= vote_d;
                    if (cnt_q == CNT_W'(SAMP_CYC - 1)) begin
                        result_q <= (vote_d > VCNT_W'(NSAMP / 2));
                        ack_q    <= NREQ'(1) << sel_q;
                        rr_q     <= rr_d;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`else
                    result_q <= comp_sync;
                    ack_q    <= NREQ'(1) << sel_q;
                    rr_q     <= rr_d;
                    state_q  <= DONE;
`endif
                end
                DONE: begin
                    bias_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ack_o     = ack_q;
    assign result_o  = result_q;
    assign sel_o     = sel_q;
    assign bias_en_o = bias_q;
    assign busy_o    = busy_q;

endmodule
